// File: rtl/pos_pkg.sv
// Shared constants and types for the axis position update scheduler.
// Optional SATURATE_EN build macro clamps overflowing results.
package pos_pkg;
  localparam int DEF_WIDTH = 16;

  localparam logic [1:0] AXIS_X = 2'd0;
  localparam logic [1:0] AXIS_Y = 2'd1;
  localparam logic [1:0] AXIS_Z = 2'd2;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } state_t;
endpackage

// File: rtl/rr_arbiter3.sv
// Combinational 3-way round-robin arbiter; search starts after last.
module rr_arbiter3
  import pos_pkg::*;
(
  input  logic [2:0] pending,
  input  logic [1:0] last,
  output logic [2:0] grant
);
  logic [2:0] rot;
  logic [2:0] pick;

  // rot[0] is the highest-priority axis for this pointer
  always_comb begin
    rot   = pending;
    grant = '0;
    pick  = '0;
    unique case (last)
      AXIS_X: begin
        rot   = {pending[0], pending[2], pending[1]};
        pick  = rot & (~rot + 3'd1);
        grant = {pick[1], pick[0], pick[2]};
      end
      AXIS_Y: begin
        rot   = {pending[1], pending[0], pending[2]};
        pick  = rot & (~rot + 3'd1);
        grant = {pick[0], pick[2], pick[1]};
      end
      default: begin
        rot   = pending;
        pick  = rot & (~rot + 3'd1);
        grant = pick;
      end
    endcase
  end
endmodule

// File: rtl/axis_update_scheduler.sv
// Shares one external add/sub unit among X/Y/Z position updates.
// Build macro SATURATE_EN clamps overflowing results to signed limits.
module axis_update_scheduler
  import pos_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       req,
  input  logic [2:0]       dir,
  input  logic [WIDTH-1:0] vel_x,
  input  logic [WIDTH-1:0] vel_y,
  input  logic [WIDTH-1:0] vel_z,
  input  logic             load,
  input  logic [1:0]       load_axis,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clr_ovf,
  output logic             as_mode,
  output logic [WIDTH-1:0] as_a,
  output logic [WIDTH-1:0] as_b,
  output logic             as_cin,
  input  logic [WIDTH-1:0] as_sum,
  input  logic             as_cout,
  output logic [WIDTH-1:0] pos_x,
  output logic [WIDTH-1:0] pos_y,
  output logic [WIDTH-1:0] pos_z,
  output logic [2:0]       ack,
  output logic             busy,
  output logic [2:0]       ovf
);
  localparam int MSB = WIDTH - 1;

  state_t           state_q, state_d;
  logic [2:0]       pend_q, req_eff, gnt, ovf_q;
  logic [1:0]       last_q, g_q, g_sel;
  logic             op_dir, sel_dir, of, load_hit, wb_now;
  logic [WIDTH-1:0] op_a, op_b, sel_pos, sel_vel, beff, wr_val;
  logic [WIDTH-1:0] pos_q [3];
  logic             unused_cout;

  assign req_eff = pend_q | req;

  rr_arbiter3 u_arb (
    .pending (req_eff),
    .last    (last_q),
    .grant   (gnt)
  );

  always_comb begin
    g_sel   = AXIS_X;
    sel_pos = pos_q[0];
    sel_vel = vel_x;
    sel_dir = dir[0];
    unique case (1'b1)
      gnt[1]: begin
        g_sel   = AXIS_Y;
        sel_pos = pos_q[1];
        sel_vel = vel_y;
        sel_dir = dir[1];
      end
      gnt[2]: begin
        g_sel   = AXIS_Z;
        sel_pos = pos_q[2];
        sel_vel = vel_z;
        sel_dir = dir[2];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req_eff) state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign wb_now   = (state_q == EXEC);
  assign beff     = op_b ^ {WIDTH{op_dir == MODE_SUB}};
  assign of       = (op_a[MSB] == beff[MSB]) && (as_sum[MSB] != op_a[MSB]);
  assign load_hit = load && (load_axis == g_q);

`ifdef SATURATE_EN
  // both operands non-negative means the overflow went positive
  assign wr_val = !of ? as_sum :
                  op_a[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
`else
  assign wr_val = as_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      last_q  <= AXIS_Z;
      g_q     <= AXIS_X;
      op_dir  <= MODE_ADD;
      op_a    <= '0;
      op_b    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && |req_eff) begin
        g_q    <= g_sel;
        op_dir <= sel_dir;
        op_a   <= sel_pos;
        op_b   <= sel_vel;
      end
      if (state_q == WB) last_q <= g_q;
      pend_q <= (pend_q & ~ack) | req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) pos_q[i] <= '0;
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (load && load_axis == 2'(i))
          pos_q[i] <= load_value;
        else if (wb_now && g_q == 2'(i))
          pos_q[i] <= wr_val;
        if (wb_now && g_q == 2'(i) && of && !load_hit)
          ovf_q[i] <= 1'b1;
        else if (clr_ovf)
          ovf_q[i] <= 1'b0;
      end
    end
  end

  assign ack         = (state_q == WB) ? 3'(3'b001 << g_q) : 3'b000;
  assign busy        = (state_q != IDLE);
  assign ovf         = ovf_q;
  assign as_mode     = op_dir;
  assign as_cin      = op_dir;
  assign as_a        = op_a;
  assign as_b        = op_b;
  assign pos_x       = pos_q[AXIS_X];
  assign pos_y       = pos_q[AXIS_Y];
  assign pos_z       = pos_q[AXIS_Z];
  assign unused_cout = as_cout;
endmodule

// File: tb/tb_axis_update_scheduler.sv
// Randomized and directed bench for axis_update_scheduler.
// Uses a transaction-level reference model of the update schedule.
module tb_axis_update_scheduler;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req, dir;
  logic [15:0] vel_x, vel_y, vel_z;
  logic        load;
  logic [1:0]  load_axis;
  logic [15:0] load_value;
  logic        clr_ovf;
  logic        as_mode, as_cin, as_cout, busy;
  logic [15:0] as_a, as_b, as_sum;
  logic [15:0] pos_x, pos_y, pos_z;
  logic [2:0]  ack, ovf;

  int total = 0;
  int bad = 0;

  axis_update_scheduler #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .dir(dir),
    .vel_x(vel_x), .vel_y(vel_y), .vel_z(vel_z),
    .load(load), .load_axis(load_axis), .load_value(load_value),
    .clr_ovf(clr_ovf), .as_mode(as_mode), .as_a(as_a), .as_b(as_b),
    .as_cin(as_cin), .as_sum(as_sum), .as_cout(as_cout),
    .pos_x(pos_x), .pos_y(pos_y), .pos_z(pos_z),
    .ack(ack), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // external shared add/sub unit
  assign {as_cout, as_sum} = 17'(as_a) + 17'(as_b ^ {16{as_mode}}) + 17'(as_cin);

  // reference model: update phase 0=idle, 1=adder busy, 2=writeback
  logic [15:0] m_pos [3];
  logic [2:0]  m_ovf, m_pend;
  int          m_last, m_phase, m_g;
  logic [15:0] m_a, m_b;
  logic        m_d;

  function automatic logic [15:0] vel_of(int ax);
    return ax == 0 ? vel_x : ax == 1 ? vel_y : vel_z;
  endfunction

  task automatic model_step();
    logic [2:0] eff, novf;
    int r, ax;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) m_pos[i] = '0;
      m_ovf = '0; m_pend = '0; m_last = 2; m_phase = 0; m_g = 0;
      m_a = '0; m_b = '0; m_d = 1'b0;
      return;
    end
    eff  = m_pend | req;
    novf = clr_ovf ? 3'b000 : m_ovf;
    case (m_phase)
      0: if (eff != 0) begin
        for (int k = 3; k >= 1; k--) begin
          ax = (m_last + k) % 3;
          if (eff[ax]) m_g = ax;
        end
        m_a = m_pos[m_g]; m_b = vel_of(m_g); m_d = dir[m_g];
        m_phase = 1;
      end
      1: begin
        r = m_d ? int'($signed(m_a)) - int'($signed(m_b))
                : int'($signed(m_a)) + int'($signed(m_b));
        if (!(load && int'(load_axis) == m_g)) begin
`ifdef SATURATE_EN
          if (r > 32767) m_pos[m_g] = 16'h7FFF;
          else if (r < -32768) m_pos[m_g] = 16'h8000;
          else m_pos[m_g] = r[15:0];
`else
          m_pos[m_g] = r[15:0];
`endif
          if (r > 32767 || r < -32768) novf[m_g] = 1'b1;
        end
        m_phase = 2;
      end
      default: begin
        m_pend[m_g] = 1'b0;
        m_last = m_g;
        m_phase = 0;
      end
    endcase
    m_pend = m_pend | req;
    if (load && load_axis != 2'd3) m_pos[load_axis] = load_value;
    m_ovf = novf;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("ack", 32'(ack), m_phase == 2 ? 32'(1 << m_g) : 32'd0);
      chk("pos_x", 32'(pos_x), 32'(m_pos[0]));
      chk("pos_y", 32'(pos_y), 32'(m_pos[1]));
      chk("pos_z", 32'(pos_z), 32'(m_pos[2]));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      chk("cin", 32'(as_cin), 32'(as_mode));
      if (m_phase == 1) begin
        chk("as_a", 32'(as_a), 32'(m_a));
        chk("as_b", 32'(as_b), 32'(m_b));
        chk("as_mode", 32'(as_mode), 32'(m_d));
      end
    end
  end

  task automatic idle_in();
    req = '0; load = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  initial begin
    idle_in();
    dir = '0; vel_x = '0; vel_y = '0; vel_z = '0;
    load_axis = '0; load_value = '0;
    rst_n = 1'b0;
    cyc(2);
    chk("rst_pos", {pos_x, pos_y}, 32'd0);
    chk("rst_flags", {26'd0, ack, ovf}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_as", {as_a, as_b}, 32'd0);
    rst_n = 1'b1;
    cyc(1);

    // single X update, two-cycle latency
    vel_x = 16'd5; dir = 3'b000; req = 3'b001;
    cyc(1); req = '0;
    chk("t1_busy", 32'(busy), 32'd1);
    cyc(1);
    chk("t1_ack", 32'(ack), 32'b001);
    chk("t1_pos", 32'(pos_x), 32'd5);
    cyc(1);

    // all three at once, round-robin X, Y, Z
    do_reset();
    vel_x = 16'd1; vel_y = 16'd2; vel_z = 16'd3; req = 3'b111;
    for (int c = 1; c <= 8; c++) begin
      cyc(1); req = '0;
      if (c == 2) chk("t2_ackx", 32'(ack), 32'b001);
      if (c == 5) chk("t2_acky", 32'(ack), 32'b010);
      if (c == 8) chk("t2_ackz", 32'(ack), 32'b100);
    end
    chk("t2_pos", {8'd0, pos_x[7:0], pos_y[7:0], pos_z[7:0]}, 32'h00010203);
    cyc(1);

    // 0 - 1 on Y
    load = 1'b1; load_axis = 2'd1; load_value = 16'd0;
    cyc(1); load = 1'b0;
    vel_y = 16'd1; dir = 3'b010; req = 3'b010;
    cyc(1); req = '0;
    cyc(1);
    chk("t3_pos", 32'(pos_y), 32'h0000FFFF);
    chk("t3_ovf", 32'(ovf[1]), 32'd0);
    cyc(1);

    // 0x7FFF + 1 on Z overflows
    load = 1'b1; load_axis = 2'd2; load_value = 16'h7FFF;
    cyc(1); load = 1'b0;
    vel_z = 16'd1; dir = 3'b000; req = 3'b100;
    cyc(1); req = '0;
    cyc(1);
`ifdef SATURATE_EN
    chk("t4_pos", 32'(pos_z), 32'h00007FFF);
`else
    chk("t4_pos", 32'(pos_z), 32'h00008000);
`endif
    chk("t4_ovf", 32'(ovf[2]), 32'd1);
    clr_ovf = 1'b1;
    cyc(1); clr_ovf = 1'b0;
    chk("t4_clr", 32'(ovf), 32'd0);

    // load collides with X writeback, then re-request in WB
    vel_x = 16'd3; req = 3'b001;
    cyc(1); req = '0;
    load = 1'b1; load_axis = 2'd0; load_value = 16'h1234;
    cyc(1); load = 1'b0;
    chk("t5_ack", 32'(ack), 32'b001);
    chk("t5_pos", 32'(pos_x), 32'h1234);
    req = 3'b001;
    cyc(1); req = '0;
    cyc(2);
    chk("t5_ack2", 32'(ack), 32'b001);
    chk("t5_pos2", 32'(pos_x), 32'h1237);
    cyc(1);

    // reset in the middle of EXEC
    vel_y = 16'd9; req = 3'b010;
    cyc(1); req = '0;
    chk("t6_exec", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_pos", {8'd0, pos_x[7:0], pos_y[7:0], pos_z[7:0]}, 32'd0);
    chk("t6_flags", {26'd0, ack, ovf}, 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    cyc(1); rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cyc(1);
      chk("t6_noack", 32'(ack), 32'd0);
    end

    // random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      req        = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      dir        = 3'($urandom);
      vel_x      = 16'($urandom);
      vel_y      = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      vel_z      = 16'($urandom);
      load       = ($urandom_range(0, 7) == 0);
      load_axis  = 2'($urandom);
      load_value = ($urandom_range(0, 1) == 1) ? 16'h7FF0 : 16'($urandom);
      clr_ovf    = ($urandom_range(0, 15) == 0);
      cyc(1);
    end
    idle_in();
    cyc(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
